// File: rtl/conv_pkg.sv
// Shared types for the 3x3 window generator: default pixel width, tap type, FSM states.
package conv_pkg;
  localparam int DEF_DATA_W = 8;

  typedef logic signed [DEF_DATA_W-1:0] tap_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: synchronous write, combinational read returning pre-write data.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; rows 0 and 1 of each frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator over raster-order pixels with two row buffers.
// Optional macro WIN_COUNT_EN adds a 16-bit retired-window counter port.
//
// state | meaning
// FILL  | rows 0-1 of a frame arriving, no windows emitted
// RUN   | rows 2..IMG_H-1, window emitted for every col >= 2
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] win_00,
  output logic [DATA_W-1:0] win_01,
  output logic [DATA_W-1:0] win_02,
  output logic [DATA_W-1:0] win_10,
  output logic [DATA_W-1:0] win_11,
  output logic [DATA_W-1:0] win_12,
  output logic [DATA_W-1:0] win_20,
  output logic [DATA_W-1:0] win_21,
  output logic [DATA_W-1:0] win_22
`ifdef WIN_COUNT_EN
  ,
  output logic [15:0]       win_count
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_2    = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_1    = RW'(1);

  state_t            state, next_state, cur_state;
  logic [CW-1:0]     col, eff_col;
  logic [RW-1:0]     row, eff_row;
  logic              accept, emit, at_last_col, at_last_row;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // in_sof forces the current pixel to (0,0) of a fresh frame.
  always_comb begin
    cur_state   = in_sof ? FILL : state;
    eff_col     = in_sof ? '0 : col;
    eff_row     = in_sof ? '0 : row;
    at_last_col = (eff_col == COL_LAST);
    at_last_row = (eff_row == ROW_LAST);
    emit        = accept && (cur_state == RUN) && (eff_col >= COL_2);
    next_state  = state;
    if (accept) begin
      next_state = cur_state;
      if (cur_state == FILL && at_last_col && eff_row == ROW_1) next_state = RUN;
      else if (cur_state == RUN && at_last_col && at_last_row) next_state = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  // lb0 holds row-1, lb1 holds row-2; lb1 is refilled from lb0's pre-write data.
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(eff_col), .wr_data(in_data), .rd_data(lb0_rd)
  );
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(eff_col), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win_00 <= '0; win_01 <= '0; win_02 <= '0;
      win_10 <= '0; win_11 <= '0; win_12 <= '0;
      win_20 <= '0; win_21 <= '0; win_22 <= '0;
    end else if (accept) begin
      win_00 <= win_01; win_01 <= win_02; win_02 <= lb1_rd;
      win_10 <= win_11; win_11 <= win_12; win_12 <= lb0_rd;
      win_20 <= win_21; win_21 <= win_22; win_22 <= in_data;
      out_valid <= emit;
      out_last  <= emit && at_last_col && at_last_row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef WIN_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    win_count <= '0;
    else if (out_valid && out_ready) win_count <= win_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 4x4 image against a frame-array reference model.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last;
  logic [7:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
`ifdef WIN_COUNT_EN
  logic [15:0] win_count;
`endif

  conv_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .win_00(win_00), .win_01(win_01), .win_02(win_02),
    .win_10(win_10), .win_11(win_11), .win_12(win_12),
    .win_20(win_20), .win_21(win_21), .win_22(win_22)
`ifdef WIN_COUNT_EN
    , .win_count(win_count)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  tap_t        img [H][W];
  int          mr = 0, mc = 0;
  logic [72:0] q [$];
  int          ready_mode = 0;
  int          stall_left = 0;
  int          n_ret_frame = 0;
  int          n_ret_since_rst = 0;
  logic [72:0] ret_log [8];

  function automatic logic [71:0] taps();
    return {win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: store pixel at its frame position, emit window from the stored image.
  task automatic model_accept(input logic sof, input tap_t d);
    logic [71:0] w;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      w = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w = {w[63:0], img[mr-2+i][mc-2+j]};
      q.push_back({(mr == H-1 && mc == W-1), w});
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic step(input logic v, input logic sof, input tap_t d, output logic acc);
    logic r;
    logic ev;
    @(negedge clk);
    r = 1'b1;
    if (ready_mode == 1) r = 1'($urandom_range(0, 1));
    else if (ready_mode == 2 && out_valid && n_ret_frame == 1 && stall_left > 0) begin
      r = 1'b0;
      stall_left--;
    end
    in_valid = v; in_sof = sof; in_data = d; out_ready = r;
    #1;
    ev = (q.size() != 0);
    chk("out_valid", out_valid, ev);
    if (ev && out_valid) chk("window", {out_last, taps()}, q[0]);
    chk("in_ready", in_ready, !ev || r);
    acc = v && in_ready;
    if (out_valid && r && ev) begin
      if (n_ret_frame < 8) ret_log[n_ret_frame] = {out_last, taps()};
      void'(q.pop_front());
      n_ret_frame++;
      n_ret_since_rst++;
    end
    if (acc) model_accept(sof, d);
  endtask

  task automatic push_pixel(input tap_t d, input logic sof);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(1'b1, sof, d, acc);
      tries++;
    end
    chk("accept", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    int   tries;
    tries = 0;
    while (q.size() != 0 && tries < 30) begin
      step(1'b0, 1'b0, '0, acc);
      tries++;
    end
    step(1'b0, 1'b0, '0, acc);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    logic acc;
    // Reset state
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_taps", taps(), 72'd0);
    chk("rst_ready", in_ready, 1'b1);
`ifdef WIN_COUNT_EN
    chk("rst_count", win_count, 16'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Frame of 1..16 with continuous ready
    n_ret_frame = 0;
    for (int p = 0; p < 16; p++) push_pixel(tap_t'(p + 1), p == 0);
    drain();
    chk("f1_count", n_ret_frame, 4);
    chk("f1_first", ret_log[0], {1'b0, 72'h01_02_03_05_06_07_09_0a_0b});
    chk("f1_last",  ret_log[3], {1'b1, 72'h06_07_08_0a_0b_0c_0e_0f_10});

    // Same frame, consumer stalls 3 cycles on the second window
    ready_mode = 2; stall_left = 3; n_ret_frame = 0;
    for (int p = 0; p < 16; p++) push_pixel(tap_t'(p + 1), p == 0);
    drain();
    ready_mode = 0;
    chk("stall_used", stall_left, 0);
    chk("stall_win2", ret_log[1], {1'b0, 72'h02_03_04_06_07_08_0a_0b_0c});
    chk("stall_count", n_ret_frame, 4);

    // Signed extremes alternating
    n_ret_frame = 0;
    for (int p = 0; p < 16; p++) push_pixel((p % 2 == 0) ? tap_t'(-128) : tap_t'(127), p == 0);
    drain();
    chk("signed_first", ret_log[0], {1'b0, 72'h80_7f_80_80_7f_80_80_7f_80});

    // in_sof mid-frame at the 7th pixel restarts counters
    n_ret_frame = 0;
    for (int p = 0; p < 6; p++) push_pixel(tap_t'(p + 1), p == 0);
    for (int p = 0; p < 16; p++) push_pixel(tap_t'(p + 101), p == 0);
    drain();
    chk("sof_count", n_ret_frame, 4);
    chk("sof_first", ret_log[0], {1'b0, 72'h65_66_67_69_6a_6b_6d_6e_6f});

    // Random data, random backpressure, random idle gaps
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 16; p++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, '0, acc);
        push_pixel(tap_t'($urandom_range(0, 255)), p == 0);
      end
    end
    drain();
    ready_mode = 0;

    // Reset mid-RUN with a window outstanding
    for (int p = 0; p < 11; p++) push_pixel(tap_t'(p + 1), p == 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_taps", taps(), 72'd0);
    q.delete();
    mr = 0; mc = 0;
    n_ret_since_rst = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Two frames after reset; the first has no sof and must still start at row 0
    n_ret_frame = 0;
    for (int p = 0; p < 16; p++) push_pixel(tap_t'(p + 1), 1'b0);
    chk("post_rst_first", ret_log[0], {1'b0, 72'h01_02_03_05_06_07_09_0a_0b});
    for (int p = 0; p < 16; p++) push_pixel(tap_t'(p + 33), p == 0);
    drain();
    chk("post_rst_count", n_ret_frame, 8);
`ifdef WIN_COUNT_EN
    chk("win_count", win_count, 16'(n_ret_since_rst));
    chk("win_count_8", win_count, 16'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
